// File: rtl/pwm_edge_calculator_pkg.sv
// Shared types and constants for the PWM edge calculator and its lanes.
package pwm_pkg;

  localparam int unsigned EDGE_W     = 13;
  localparam int unsigned PIPE_DEPTH = 5;

  typedef logic [EDGE_W-1:0]          edge_t;
  typedef logic signed [EDGE_W+1:0]   wide_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    COMMIT
  } state_e;

endpackage

// File: rtl/pwm_edge_calculator_lane.sv
// One pipelined edge lane: S1 clamp/reduce, S2 inversion, S3 edges, S4 fold.
module pwm_edge_lane
  import pwm_pkg::*;
#(
  parameter int unsigned WIDTH = 13,
  parameter int unsigned IDX_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             valid_i,
  input  logic [IDX_W-1:0] idx_i,
  input  logic [WIDTH-1:0] cycle_i,
  input  logic [WIDTH-1:0] duty_i,
  input  logic [WIDTH-1:0] phase_i,
  output logic             valid_o,
  output logic [IDX_W-1:0] idx_o,
  output logic [WIDTH-1:0] left_o,
  output logic [WIDTH-1:0] right_o,
  output logic             over_o,
  output logic             clamp_o,
  output logic             busy_o
);

  typedef logic signed [WIDTH+1:0] sw_t;

  logic             v1_q, v2_q, v3_q, v4_q;
  logic [IDX_W-1:0] i1_q, i2_q, i3_q, i4_q;
  sw_t              c1_q, d1_q, p1_q, c2_q, d2_q, q2_q, c3_q, l3_q, r3_q;
  logic             k1_q, k2_q, k3_q, k4_q, o4_q;
  logic [WIDTH-1:0] l4_q, r4_q;

  sw_t  c_w, d_w, p_w, d1_d, p1_d, q2_d, l3_d, r3_d, lf, rf;
  logic k1_d, of;

  assign c_w = sw_t'({2'b00, cycle_i});
  assign d_w = sw_t'({2'b00, duty_i});
  assign p_w = sw_t'({2'b00, phase_i});

  always_comb begin
    k1_d = d_w > c_w;
    d1_d = k1_d ? c_w : d_w;
    p1_d = (p_w >= c_w) ? p_w - c_w : p_w;
    q2_d = c1_q - p1_q;
    if (q2_d == c1_q) q2_d = '0;
    l3_d = q2_q - (d2_q >>> 1);
    r3_d = q2_q + (d2_q - (d2_q >>> 1));
    // A zero period collapses both edges to 0 instead of folding by 0.
    lf = l3_q;
    rf = r3_q;
    of = 1'b0;
    if (c3_q == '0) begin
      lf = '0;
      rf = '0;
    end else if (l3_q < 0) begin
      lf = l3_q + c3_q;
      of = 1'b1;
    end else if (r3_q >= c3_q) begin
      rf = r3_q - c3_q;
      of = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      v3_q <= 1'b0;
      v4_q <= 1'b0;
    end else begin
      v1_q <= valid_i;
      v2_q <= v1_q;
      v3_q <= v2_q;
      v4_q <= v3_q;
    end
  end

  always_ff @(posedge clk_i) begin
    i1_q <= idx_i;
    c1_q <= c_w;
    d1_q <= d1_d;
    p1_q <= p1_d;
    k1_q <= k1_d;
    i2_q <= i1_q;
    c2_q <= c1_q;
    d2_q <= d1_q;
    q2_q <= q2_d;
    k2_q <= k1_q;
    i3_q <= i2_q;
    c3_q <= c2_q;
    l3_q <= l3_d;
    r3_q <= r3_d;
    k3_q <= k2_q;
    i4_q <= i3_q;
    l4_q <= WIDTH'(lf);
    r4_q <= WIDTH'(rf);
    o4_q <= of;
    k4_q <= k3_q;
  end

  assign valid_o = v4_q;
  assign idx_o   = i4_q;
  assign left_o  = l4_q;
  assign right_o = r4_q;
  assign over_o  = o4_q;
  assign clamp_o = k4_q;
  assign busy_o  = v1_q | v2_q | v3_q;

endmodule

// File: rtl/pwm_edge_calculator.sv
// PWM edge calculator: snapshots inputs, runs LANES-wide pipeline, commits a
// double-buffered result set atomically with a DONE pulse.
module pwm_edge_calculator
  import pwm_pkg::*;
#(
  parameter int unsigned WIDTH = 13,
  parameter int unsigned DEPTH = 249,
  parameter int unsigned LANES = 1
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic [WIDTH-1:0] CYCLE [0:DEPTH-1],
  input  logic [WIDTH-1:0] DUTY  [0:DEPTH-1],
  input  logic [WIDTH-1:0] PHASE [0:DEPTH-1],
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] LEFT  [0:DEPTH-1],
  output logic [WIDTH-1:0] RIGHT [0:DEPTH-1],
  output logic             OVER  [0:DEPTH-1],
  output logic             CLAMP [0:DEPTH-1]
);

  localparam int unsigned G     = DEPTH / LANES;
  localparam int unsigned IDX_W = (G > 1) ? $clog2(G) : 1;
  localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  if (DEPTH % LANES != 0) begin : g_depth_chk
    $error("DEPTH must be a multiple of LANES");
  end

  state_e           state_q, state_d;
  logic [IDX_W-1:0] grp_q, grp_d;
  logic             done_q, issue, take;

  logic [WIDTH-1:0] cyc_s [0:DEPTH-1];
  logic [WIDTH-1:0] dut_s [0:DEPTH-1];
  logic [WIDTH-1:0] ph_s  [0:DEPTH-1];

  logic [WIDTH-1:0] sh_l_q [0:DEPTH-1];
  logic [WIDTH-1:0] sh_r_q [0:DEPTH-1];
  logic             sh_o_q [0:DEPTH-1];
  logic             sh_k_q [0:DEPTH-1];
  logic [WIDTH-1:0] left_q [0:DEPTH-1];
  logic [WIDTH-1:0] right_q [0:DEPTH-1];
  logic             over_q [0:DEPTH-1];
  logic             clamp_q [0:DEPTH-1];

  logic             lane_v    [LANES];
  logic [IDX_W-1:0] lane_idx  [LANES];
  logic [AW-1:0]    lane_addr [LANES];
  logic [WIDTH-1:0] lane_l    [LANES];
  logic [WIDTH-1:0] lane_r    [LANES];
  logic             lane_o    [LANES];
  logic             lane_k    [LANES];
  logic [LANES-1:0] lane_busy;

  assign take = (state_q == IDLE) && START;

  always_comb begin
    state_d = state_q;
    grp_d   = grp_q;
    issue   = 1'b0;
    case (state_q)
      IDLE: if (START) begin
        state_d = RUN;
        grp_d   = '0;
      end
      RUN: begin
        issue = 1'b1;
        if (grp_q == IDX_W'(G - 1)) state_d = DRAIN;
        else grp_d = grp_q + 1'b1;
      end
      DRAIN:   if (lane_busy == '0) state_d = COMMIT;
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= IDLE;
      grp_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grp_q   <= grp_d;
      done_q  <= (state_q == COMMIT);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST_N && take) begin
      cyc_s <= CYCLE;
      dut_s <= DUTY;
      ph_s  <= PHASE;
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [AW-1:0] rd_addr;
    assign rd_addr      = AW'(grp_q * LANES + i);
    assign lane_addr[i] = AW'(lane_idx[i] * LANES + i);

    pwm_edge_lane #(
      .WIDTH(WIDTH),
      .IDX_W(IDX_W)
    ) u_lane (
      .clk_i  (CLK),
      .rst_ni (RST_N),
      .valid_i(issue),
      .idx_i  (grp_q),
      .cycle_i(cyc_s[rd_addr]),
      .duty_i (dut_s[rd_addr]),
      .phase_i(ph_s[rd_addr]),
      .valid_o(lane_v[i]),
      .idx_o  (lane_idx[i]),
      .left_o (lane_l[i]),
      .right_o(lane_r[i]),
      .over_o (lane_o[i]),
      .clamp_o(lane_k[i]),
      .busy_o (lane_busy[i])
    );
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      sh_l_q  <= '{default: '0};
      sh_r_q  <= '{default: '0};
      sh_o_q  <= '{default: 1'b0};
      sh_k_q  <= '{default: 1'b0};
      left_q  <= '{default: '0};
      right_q <= '{default: '0};
      over_q  <= '{default: 1'b0};
      clamp_q <= '{default: 1'b0};
    end else begin
      for (int unsigned i = 0; i < LANES; i++) begin
        if (lane_v[i]) begin
          sh_l_q[lane_addr[i]] <= lane_l[i];
          sh_r_q[lane_addr[i]] <= lane_r[i];
          sh_o_q[lane_addr[i]] <= lane_o[i];
          sh_k_q[lane_addr[i]] <= lane_k[i];
        end
      end
      if (state_q == COMMIT) begin
        left_q  <= sh_l_q;
        right_q <= sh_r_q;
        over_q  <= sh_o_q;
        clamp_q <= sh_k_q;
      end
    end
  end

  assign BUSY  = (state_q != IDLE);
  assign DONE  = done_q;
  assign LEFT  = left_q;
  assign RIGHT = right_q;
  assign OVER  = over_q;
  assign CLAMP = clamp_q;

endmodule

// File: tb/tb_pwm_edge_calculator.sv
// Directed bench for pwm_edge_calculator at LANES=1 and LANES=83.
module tb_pwm_edge_calculator;

  localparam int W = 13;
  localparam int D = 249;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, start1, start83;
  logic [W-1:0] cyc [0:D-1];
  logic [W-1:0] dty [0:D-1];
  logic [W-1:0] ph  [0:D-1];

  logic         busy1, done1, busy83, done83;
  logic [W-1:0] l1 [0:D-1];
  logic [W-1:0] r1 [0:D-1];
  logic         o1 [0:D-1];
  logic         k1 [0:D-1];
  logic [W-1:0] l83 [0:D-1];
  logic [W-1:0] r83 [0:D-1];
  logic         o83 [0:D-1];
  logic         k83 [0:D-1];

  pwm_edge_calculator #(.WIDTH(W), .DEPTH(D), .LANES(1)) u_dut1 (
    .CLK(clk), .RST_N(rst_n), .START(start1),
    .CYCLE(cyc), .DUTY(dty), .PHASE(ph),
    .BUSY(busy1), .DONE(done1),
    .LEFT(l1), .RIGHT(r1), .OVER(o1), .CLAMP(k1)
  );

  pwm_edge_calculator #(.WIDTH(W), .DEPTH(D), .LANES(83)) u_dut83 (
    .CLK(clk), .RST_N(rst_n), .START(start83),
    .CYCLE(cyc), .DUTY(dty), .PHASE(ph),
    .BUSY(busy83), .DONE(done83),
    .LEFT(l83), .RIGHT(r83), .OVER(o83), .CLAMP(k83)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_all(input int c, input int d, input int p);
    for (int i = 0; i < D; i++) begin
      cyc[i] = W'(c);
      dty[i] = W'(d);
      ph[i]  = W'(p);
    end
  endtask

  // Pulses START on the chosen DUT and returns edges from sample to DONE.
  task automatic run(input bit wide, output int edges);
    @(negedge clk);
    if (wide) start83 = 1'b1; else start1 = 1'b1;
    @(negedge clk);
    start83 = 1'b0;
    start1  = 1'b0;
    edges = 0;
    while (!(wide ? done83 : done1) && edges < 1000) begin
      @(negedge clk);
      edges++;
    end
  endtask

  function automatic void model(input int c, input int d, input int p,
                                output int l, output int r, output int o, output int k);
    int q;
    k = (d > c) ? 1 : 0;
    if (d > c) d = c;
    if (c == 0) begin
      l = 0; r = 0; o = 0;
      return;
    end
    if (p >= c) p = p - c;
    q = (c - p) % c;
    l = q - d / 2;
    r = q + (d + 1) / 2;
    o = 0;
    if (l < 0) begin
      l = l + c; o = 1;
    end else if (r >= c) begin
      r = r - c; o = 1;
    end
  endfunction

  initial begin
    int e, n, changes;
    int ml, mr, mo, mk;

    rst_n = 1'b0; start1 = 1'b0; start83 = 1'b0;
    set_all(0, 0, 0);
    repeat (3) @(negedge clk);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    chk("reset_busy1", busy1, 0);
    chk("reset_done1", done1, 0);
    chk("reset_busy83", busy83, 0);
    chk("reset_left0", l1[0], 0);
    chk("reset_right5", r1[5], 0);
    chk("reset_over0", o1[0], 0);
    chk("reset_clamp0", k1[0], 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("start_during_reset_busy", busy1, 0);

    // Basic edges, LANES=1.
    set_all(4096, 2048, 0);
    run(0, e);
    chk("basic_latency", e, 254);
    chk("basic_left0", l1[0], 3072);
    chk("basic_right0", r1[0], 1024);
    chk("basic_over0", o1[0], 1);
    chk("basic_clamp0", k1[0], 0);
    chk("basic_left248", l1[248], 3072);
    chk("basic_busy_low", busy1, 0);
    @(negedge clk);
    chk("done_one_cycle", done1, 0);

    // Clamp, phase reduction, full duty, zero period, odd duty.
    set_all(0, 5, 0);
    cyc[0] = 100; dty[0] = 150; ph[0] = 30;
    cyc[1] = 100; dty[1] = 0;   ph[1] = 130;
    cyc[2] = 50;  dty[2] = 50;  ph[2] = 10;
    cyc[3] = 0;   dty[3] = 0;   ph[3] = 7;
    cyc[5] = 10;  dty[5] = 3;   ph[5] = 0;
    run(0, e);
    chk("mix_latency", e, 254);
    chk("clamp_left", l1[0], 20);
    chk("clamp_right", r1[0], 20);
    chk("clamp_over", o1[0], 1);
    chk("clamp_flag", k1[0], 1);
    chk("phred_left", l1[1], 70);
    chk("phred_right", r1[1], 70);
    chk("phred_over", o1[1], 0);
    chk("phred_clamp", k1[1], 0);
    chk("full_left", l1[2], 15);
    chk("full_right", r1[2], 15);
    chk("full_over", o1[2], 1);
    chk("czero_left", l1[3], 0);
    chk("czero_clamp_d0", k1[3], 0);
    chk("czero_right_d5", r1[4], 0);
    chk("czero_over_d5", o1[4], 0);
    chk("czero_clamp_d5", k1[4], 1);
    chk("odd_left", l1[5], 9);
    chk("odd_right", r1[5], 2);
    chk("odd_over", o1[5], 1);

    // Wide lanes, per-channel reference model.
    for (int i = 0; i < D; i++) begin
      cyc[i] = 1000; dty[i] = W'(i); ph[i] = W'(i);
    end
    run(1, e);
    chk("wide_latency", e, 8);
    chk("wide_left248", l83[248], 628);
    chk("wide_right248", r83[248], 876);
    for (int i = 0; i < D; i++) begin
      model(1000, i, i, ml, mr, mo, mk);
      chk($sformatf("wide_left%0d", i), l83[i], ml);
      chk($sformatf("wide_right%0d", i), r83[i], mr);
      chk($sformatf("wide_over%0d", i), o83[i], mo);
      chk($sformatf("wide_clamp%0d", i), k83[i], mk);
    end
    chk("hold_narrow_left0", l1[0], 20);

    // Ignored START mid-run, then START in the DONE cycle.
    set_all(200, 20, 0);
    @(negedge clk);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    e = 0;
    while (!done1 && e < 1000) begin
      if (e == 50) start1 = 1'b1;
      if (e == 51) start1 = 1'b0;
      @(negedge clk);
      e++;
    end
    chk("ignored_start_latency", e, 254);
    chk("runA_left0", l1[0], 190);
    chk("runA_right0", r1[0], 10);
    start1 = 1'b1;
    set_all(200, 20, 50);
    @(negedge clk);
    start1 = 1'b0;
    set_all(300, 100, 0);
    e = 0;
    changes = 0;
    while (!done1 && e < 1000) begin
      if (l1[0] !== 190 || r1[0] !== 10 || l1[248] !== 190) changes++;
      @(negedge clk);
      e++;
    end
    chk("b2b_latency", e, 254);
    chk("b2b_no_early_change", changes, 0);
    chk("runB_left0", l1[0], 140);
    chk("runB_right0", r1[0], 160);
    chk("runB_over0", o1[0], 0);
    chk("runB_left100", l1[100], 140);
    n = 0;
    repeat (20) begin
      @(negedge clk);
      if (done1) n++;
    end
    chk("no_extra_done", n, 0);

    // Reset at edge 100 of a run.
    set_all(4096, 2048, 0);
    @(negedge clk);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    repeat (99) @(negedge clk);
    chk("prereset_busy", busy1, 1);
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("midreset_busy", busy1, 0);
    chk("midreset_done", done1, 0);
    chk("midreset_left0", l1[0], 0);
    chk("midreset_right0", r1[0], 0);
    chk("midreset_left200", l1[200], 0);
    chk("midreset_over0", o1[0], 0);
    chk("midreset_wide_left10", l83[10], 0);
    rst_n = 1'b1;
    n = 0;
    repeat (270) begin
      @(negedge clk);
      if (done1) n++;
    end
    chk("aborted_no_done", n, 0);
    set_all(100, 150, 30);
    run(0, e);
    chk("post_reset_latency", e, 254);
    chk("post_reset_left7", l1[7], 20);
    chk("post_reset_clamp7", k1[7], 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pwm_edge_calculator.md
# pwm_edge_calculator

Parametrised successor to the per-transducer PWM preconditioner. It snapshots cycle, duty and phase for DEPTH transducers and computes the PWM rising edge (LEFT), falling edge (RIGHT) and wrap flag (OVER) for each. Work runs through a LANES-wide pipeline, with duty clamping and phase reduction. Results are double-buffered and committed atomically with a DONE pulse, so the downstream PWM generators never see a partially updated set.

## Interface
- WIDTH, 13: bit width of cycle, duty, phase and edges.
- DEPTH, 249: number of transducers. Must be a multiple of LANES; checked by an elaboration-time assertion.
- LANES, 1: transducers processed per clock. Valid values are 1, 3, 83 and 249 for the default DEPTH.
- CLK  in  1  system clock; single clock domain.
- RST_N  in  1  synchronous, active-low reset.
- START  in  1  request a new computation; sampled only in IDLE.
- CYCLE[0:DEPTH-1]  in  WIDTH each  PWM period in ticks.
- DUTY[0:DEPTH-1]  in  WIDTH each  pulse width in ticks.
- PHASE[0:DEPTH-1]  in  WIDTH each  phase delay in ticks.
- BUSY  out  1  high while a computation is in flight.
- DONE  out  1  one-cycle pulse, asserted in the first cycle new results are visible.
- LEFT[0:DEPTH-1]  out  WIDTH each  rising edge, in the range 0..cycle-1.
- RIGHT[0:DEPTH-1]  out  WIDTH each  falling edge, in the range 0..cycle-1.
- OVER[0:DEPTH-1]  out  1 each  pulse wraps the period boundary.
- CLAMP[0:DEPTH-1]  out  1 each  duty was larger than cycle and was saturated.

## Operation
- States:
  - IDLE: START=1 snapshots all CYCLE, DUTY and PHASE inputs and moves to RUN.
  - RUN: issues one group of LANES transducers per cycle, G = DEPTH/LANES groups in total. Once all groups have been issued, moves to DRAIN.
  - DRAIN: waits for the pipeline to empty, then moves to COMMIT.
  - COMMIT: copies the shadow registers to the outputs in one cycle, then returns to IDLE.
- START is ignored outside IDLE. It is not queued.
- Per-lane arithmetic is signed, WIDTH+2 bits wide. For each transducer, with c=cycle, d=duty, p=phase:
  - Clamp: if d > c, then d = c and CLAMP = 1.
  - Phase reduction: if p ≥ c, then p = p - c (one conditional subtract). Inputs with p ≥ 2c are outside the contract.
  - Inverted phase: q = c - p; if q == c, then q = 0.
  - Edges: l = q - floor(d/2), r = q + ceil(d/2).
  - Fold: if l < 0, then l = l + c and OVER = 1. Else if r ≥ c, then r = r - c and OVER = 1. Otherwise OVER = 0.
  - Both folds can never apply at once, because d ≤ c after the clamp.
- Resulting encodings:
  - d = 0 gives LEFT = RIGHT = q and OVER = 0 (output off).
  - d = c gives LEFT = RIGHT and OVER = 1 (output fully on).
- c = 0 gives LEFT = RIGHT = 0 and OVER = 0. CLAMP = 1 if d ≠ 0.
- Outputs hold their values indefinitely between commits.

## Timing
- Call the edge that samples START in IDLE edge 0.
  - BUSY rises at edge 0.
  - Group k enters stage 1 at edge k+1.
  - Pipeline stages: S1 clamp and reduce, S2 inversion, S3 edges, S4 fold, S5 shadow write.
  - The last group reaches the shadow registers at edge G+4.
  - Outputs update and DONE rises at edge G+5; BUSY falls at the same edge.
  - Total latency from START sample to DONE is G+5 cycles. Default configuration: 254 cycles at LANES=1, 8 cycles at LANES=83.
- DONE is high for exactly one cycle. START may be asserted in the DONE cycle and is accepted; the next DONE follows G+5 cycles later.
- Input changes after edge 0 do not affect the computation in flight.
- Reset values, with RST_N low at any edge:
  - state = IDLE, BUSY = 0, DONE = 0.
  - All LEFT, RIGHT, OVER and CLAMP outputs = 0; shadow registers = 0.
  - Pipeline valid bits are cleared.
- Reset asserted mid-run aborts the computation: no DONE, and outputs are forced to 0.
- START and RST_N low in the same cycle: reset wins.

## Structure
- Shared package pwm_pkg holds:
  - the edge_t typedef, logic [WIDTH-1:0];
  - the wide_t typedef, logic signed [WIDTH+1:0];
  - the state enum {IDLE, RUN, DRAIN, COMMIT};
  - the constant PIPE_DEPTH = 5.
- Sub-module pwm_edge_lane holds one pipelined lane (stages S1–S4, with a valid bit and a group index carried alongside the data). The top level instantiates LANES copies through a generate loop.
- Top level holds: FSM, group counter, input snapshot, shadow and output register arrays.

## Test plan
- Basic edge computation. LANES=1, all channels c=4096, d=2048, p=0 → LEFT=3072, RIGHT=1024, OVER=1, CLAMP=0; DONE pulses exactly 254 cycles after START.
- Duty clamp. c=100, d=150, p=30 → d clamped to 100, CLAMP=1, LEFT=RIGHT=20, OVER=1.
- Phase reduction and zero duty. c=100, d=0, p=130 → p reduces to 30, q=70, LEFT=RIGHT=70, OVER=0, CLAMP=0.
- Wide-lane configuration. LANES=83, channel i set to c=1000, d=i, p=i → each channel matches a reference model; DONE arrives 8 cycles after START.
- Ignored and back-to-back START. A second START while BUSY is ignored, with exactly one DONE produced. START asserted in the DONE cycle is accepted, and the new results replace the old ones atomically: no output changes before the second DONE.
- Reset mid-run. RST_N is pulled low at edge 100 of a LANES=1 run → BUSY=0, no DONE pulse, all outputs read 0. A fresh START after reset completes normally.
